// File: rtl/ram_master_if.sv
// ram_master control/status and RAM pin bundle.
// master: sequencer side; slave: requester plus RAM side.
interface ram_master_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic             start;
    logic [1:0]       op;
    logic [AW-1:0]    base;
    logic [AW-1:0]    dst;
    logic [AW-1:0]    len;
    logic [DW-1:0]    fill_val;
    logic             busy;
    logic             done;
    logic             err;
    logic [DW+AW-1:0] sum;
    logic [AW-1:0]    mem_dir;
    logic [DW-1:0]    mem_dato_e;
    logic             mem_en;
    logic [DW-1:0]    mem_dato_s;

    modport master (
        input  start, op, base, dst, len, fill_val, mem_dato_s,
        output busy, done, err, sum, mem_dir, mem_dato_e, mem_en
    );

    modport slave (
        output start, op, base, dst, len, fill_val, mem_dato_s,
        input  busy, done, err, sum, mem_dir, mem_dato_e, mem_en
    );
endinterface

// File: rtl/ram_master.sv
// ram_master: FILL/SUM/COPY block sequencer for ram_syn; COPY is built only with RAM_MASTER_COPY_EN.
// Latency: done at len+1 (FILL), len+2 (SUM), 2*len+1 (COPY), 1 (reject or len=0) cycles after accept.
// Backpressure: none; start is ignored while busy, the RAM is driven one word per cycle.
module ram_master #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, FILL, SUM_RD, SUM_DRAIN, CP_RD, CP_WR, DONE} state_t;

    localparam logic [AW:0]   LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   ONE_W = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    base_q, base_d;
    logic [AW-1:0]    len_q, len_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW+AW-1:0] sum_q, sum_d;
    logic             err_q, err_d;
    logic             rd_vld_q, rd_vld_d;
    logic             src_bad, dst_bad, op_bad, reject, last;
`ifdef RAM_MASTER_COPY_EN
    logic [AW-1:0]    dst_q, dst_d;
`endif

    // Range check in AW+1 bits so base+len-1 cannot wrap back into range.
    always_comb begin
        src_bad = (bus.len != '0) && (({1'b0, bus.base} + {1'b0, bus.len} - ONE_W) > LAST);
`ifdef RAM_MASTER_COPY_EN
        op_bad  = (bus.op == 2'b11);
        dst_bad = (bus.op == 2'b10) && (bus.len != '0) &&
                  (({1'b0, bus.dst} + {1'b0, bus.len} - ONE_W) > LAST);
`else
        op_bad  = bus.op[1];
        dst_bad = 1'b0;
`endif
        reject  = op_bad | src_bad | dst_bad;
        last    = (cnt_q == (len_q - ONE_A));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        len_d    = len_q;
        fill_d   = fill_q;
        err_d    = err_q;
        sum_d    = sum_q;
        rd_vld_d = (state_q == SUM_RD);
`ifdef RAM_MASTER_COPY_EN
        dst_d    = dst_q;
`endif
        // Read data lands one cycle after each SUM_RD issue cycle.
        if (rd_vld_q) begin
            sum_d = sum_q + (DW+AW)'(bus.mem_dato_s);
        end
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d = bus.base;
                    len_d  = bus.len;
                    fill_d = bus.fill_val;
                    cnt_d  = '0;
                    err_d  = 1'b0;
`ifdef RAM_MASTER_COPY_EN
                    dst_d  = bus.dst;
`endif
                    if (bus.op == 2'b01) begin
                        sum_d = '0;
                    end
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (bus.len == '0) begin
                        state_d = DONE;
                    end else begin
                        case (bus.op)
                            2'b00:   state_d = FILL;
                            2'b01:   state_d = SUM_RD;
`ifdef RAM_MASTER_COPY_EN
                            2'b10:   state_d = CP_RD;
`endif
                            default: state_d = DONE;
                        endcase
                    end
                end
            end
            FILL: begin
                cnt_d = cnt_q + ONE_A;
                if (last) state_d = DONE;
            end
            SUM_RD: begin
                cnt_d = cnt_q + ONE_A;
                if (last) state_d = SUM_DRAIN;
            end
            SUM_DRAIN: state_d = DONE;
`ifdef RAM_MASTER_COPY_EN
            CP_RD: state_d = CP_WR;
            CP_WR: begin
                cnt_d   = cnt_q + ONE_A;
                state_d = last ? DONE : CP_RD;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
`ifdef RAM_MASTER_COPY_EN
            dst_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
            rd_vld_q <= rd_vld_d;
`ifdef RAM_MASTER_COPY_EN
            dst_q    <= dst_d;
`endif
        end
    end

    // Bus pins decode straight from state so reset kills mem_en without waiting for a clock.
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.done       = (state_q == DONE);
        bus.err        = (state_q == DONE) && err_q;
        bus.sum        = sum_q;
        bus.mem_dir    = '0;
        bus.mem_dato_e = '0;
        bus.mem_en     = 1'b0;
        case (state_q)
            FILL: begin
                bus.mem_dir    = base_q + cnt_q;
                bus.mem_dato_e = fill_q + DW'(cnt_q);
                bus.mem_en     = 1'b1;
            end
            SUM_RD: bus.mem_dir = base_q + cnt_q;
`ifdef RAM_MASTER_COPY_EN
            CP_RD: bus.mem_dir = base_q + cnt_q;
            CP_WR: begin
                bus.mem_dir    = dst_q + cnt_q;
                bus.mem_dato_e = bus.mem_dato_s;
                bus.mem_en     = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: drives a write-first, registered-read RAM and checks every cycle against a queue model.
module tb_ram_master;
    localparam int AW = 8, DW = 8, DEPTH = 11;
`ifdef RAM_MASTER_COPY_EN
    localparam bit COPY_EN = 1'b1;
`else
    localparam bit COPY_EN = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic       en;
        logic [7:0] dir;
        logic [7:0] dato;
        logic       chk_sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_master_if #(.AW(AW), .DW(DW)) bus ();
    ram_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] pre [0:10] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd100, 8'd101};
    logic [7:0] ram [0:255];
    logic [7:0] mdl_mem [0:255];
    logic       preload_req = 1'b0;

    exp_t        expq[$];
    logic [15:0] mdl_sum;
    bit          chk_en = 1'b0;
    int          checks = 0, failures = 0;
    int          cyc = 0, done_cyc = -1, wr_cnt = 0;

    // ram_syn behaviour: write-first, one-cycle registered read.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            for (int i = 0; i < 11; i++) ram[i] <= pre[i];
        end else if (bus.mem_en === 1'b1) begin
            ram[bus.mem_dir] <= bus.mem_dato_e;
            bus.mem_dato_s   <= bus.mem_dato_e;
        end else begin
            bus.mem_dato_s <= ram[bus.mem_dir];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            if (expq.size() > 0) e = expq.pop_front();
            else begin
                e = '0;
                e.chk_sum = 1'b1;
            end
            cyc++;
            check("busy", 32'(bus.busy), 32'(e.busy));
            check("done", 32'(bus.done), 32'(e.done));
            check("err", 32'(bus.err), 32'(e.err));
            check("mem_en", 32'(bus.mem_en), 32'(e.en));
            check("mem_dir", 32'(bus.mem_dir), 32'(e.dir));
            check("mem_dato_e", 32'(bus.mem_dato_e), 32'(e.dato));
            if (e.chk_sum) check("sum", 32'(bus.sum), 32'(mdl_sum));
            if (bus.done === 1'b1) done_cyc = cyc;
        end
    end

    always @(negedge clk) if (bus.mem_en === 1'b1) wr_cnt++;

    task automatic push(input logic b, d, e, en, input int dir, input int dato, input logic cs);
        exp_t r;
        r.busy = b; r.done = d; r.err = e; r.en = en;
        r.dir = 8'(dir); r.dato = 8'(dato); r.chk_sum = cs;
        expq.push_back(r);
    endtask

    // Model: what the pins must show in each cycle after accept, derived from op rules.
    task automatic build(input int op, input int base, input int dst, input int len, input int fv);
        bit rej;
        int s;
        rej = (op == 3) || (op == 2 && !COPY_EN) ||
              (len != 0 && base + len - 1 > DEPTH - 1) ||
              (op == 2 && len != 0 && dst + len - 1 > DEPTH - 1);
        if (op == 1) mdl_sum = 16'd0;
        if (!rej && len != 0) begin
            if (op == 0) begin
                for (int k = 0; k < len; k++) begin
                    push(1, 0, 0, 1, base + k, fv + k, 0);
                    mdl_mem[8'(base + k)] = 8'(fv + k);
                end
            end else if (op == 1) begin
                s = 0;
                for (int k = 0; k < len; k++) begin
                    push(1, 0, 0, 0, base + k, 0, 0);
                    s += int'(mdl_mem[8'(base + k)]);
                end
                push(1, 0, 0, 0, 0, 0, 0);
                mdl_sum = 16'(s);
            end else begin
                for (int k = 0; k < len; k++) begin
                    push(1, 0, 0, 0, base + k, 0, 0);
                    push(1, 0, 0, 1, dst + k, mdl_mem[8'(base + k)], 0);
                    mdl_mem[8'(dst + k)] = mdl_mem[8'(base + k)];
                end
            end
        end
        push(1, 1, rej, 0, 0, 0, 1);
    endtask

    task automatic run(input int op, input int base, input int dst, input int len, input int fv, output int dcyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'(op); bus.base = 8'(base); bus.dst = 8'(dst);
        bus.len = 8'(len); bus.fill_val = 8'(fv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = 2'b11; bus.base = 8'hFF; bus.dst = 8'hFF; bus.len = 8'hFF; bus.fill_val = 8'h5A;
        cyc = 0;
        done_cyc = -1;
        build(op, base, dst, len, fv);
        for (int i = 0; i < 600 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d expected cycles left", expq.size());
            expq.delete();
        end
        @(negedge clk);
        dcyc = done_cyc;
    endtask

    task automatic preload();
        @(negedge clk);
        preload_req = 1'b1;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        for (int i = 0; i < 11; i++) mdl_mem[i] = pre[i];
        @(posedge clk);
        #1 preload_req = 1'b0;
    endtask

    task automatic check_ram();
        for (int i = 0; i < DEPTH; i++) check($sformatf("ram[%0d]", i), 32'(ram[i]), 32'(mdl_mem[i]));
    endtask

    initial begin
        int d, d2, w0;
        bus.start = 1'b0; bus.op = 2'b00; bus.base = '0; bus.dst = '0; bus.len = '0; bus.fill_val = '0;
        mdl_sum = 16'd0;
        preload();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        wr_cnt = 0;
        repeat (20) @(negedge clk);
        check("idle_writes", 32'(wr_cnt), 32'd0);

        // SUM over the whole preload
        run(1, 0, 0, 11, 0, d);
        check("sum_done_cyc", 32'(d), 32'd13);
        check("sum_651", 32'(bus.sum), 32'h028B);

        // COPY 0..2 -> 5..7
        preload();
        w0 = wr_cnt;
        run(2, 0, 5, 3, 0, d);
`ifdef RAM_MASTER_COPY_EN
        check("copy_done_cyc", 32'(d), 32'd7);
        check("copy_ram5", 32'(ram[5]), 32'd90);
        check("copy_ram6", 32'(ram[6]), 32'd80);
        check("copy_ram7", 32'(ram[7]), 32'd70);
`else
        check("copy_off_done_cyc", 32'(d), 32'd1);
        check("copy_off_writes", 32'(wr_cnt - w0), 32'd0);
        check("copy_off_ram5", 32'(ram[5]), 32'd40);
`endif
        check_ram();

        // FILL 2..5 from 0x10
        preload();
        run(0, 2, 0, 4, 8'h10, d);
        check("fill_done_cyc", 32'(d), 32'd5);
        check("fill_ram2", 32'(ram[2]), 32'h10);
        check("fill_ram5", 32'(ram[5]), 32'h13);
        check("fill_ram1", 32'(ram[1]), 32'd80);
        check("fill_ram6", 32'(ram[6]), 32'd30);
        check_ram();

        // Rejects and len=0
        w0 = wr_cnt;
        run(1, 9, 0, 3, 0, d);
        check("rej_range_cyc", 32'(d), 32'd1);
        run(3, 0, 0, 2, 0, d);
        check("rej_op11_cyc", 32'(d), 32'd1);
        run(0, 4, 0, 0, 0, d);
        check("len0_cyc", 32'(d), 32'd1);
        run(1, 10, 0, 2, 0, d);
        check("rej_edge_cyc", 32'(d), 32'd1);
        check("rej_writes", 32'(wr_cnt - w0), 32'd0);

        // Last valid address, then FILL wrap at the top of the range
        run(1, 10, 0, 1, 0, d);
        check("sum_last_cyc", 32'(d), 32'd3);
        check("sum_last_val", 32'(bus.sum), 32'd101);
        run(0, 8, 0, 3, 8'hFE, d);
        check("wrap_done_cyc", 32'(d), 32'd4);
        check("wrap_ram8", 32'(ram[8]), 32'hFE);
        check("wrap_ram9", 32'(ram[9]), 32'hFF);
        check("wrap_ram10", 32'(ram[10]), 32'h00);
        check_ram();

`ifdef RAM_MASTER_COPY_EN
        // Overlapping COPY re-reads already overwritten words
        preload();
        run(2, 0, 1, 3, 0, d);
        check("ovl_ram1", 32'(ram[1]), 32'd90);
        check("ovl_ram2", 32'(ram[2]), 32'd90);
        check("ovl_ram3", 32'(ram[3]), 32'd90);
        check("ovl_ram4", 32'(ram[4]), 32'd50);
        check_ram();
`endif

        // start while busy is ignored
        preload();
        w0 = wr_cnt;
        fork
            run(0, 0, 0, 5, 8'h30, d);
            begin
                repeat (3) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        check("busy_ign_writes", 32'(wr_cnt - w0), 32'd5);
        check("busy_ign_cyc", 32'(d), 32'd6);
        check_ram();

        // Asynchronous reset in the middle of a FILL
        preload();
        w0 = wr_cnt;
        @(negedge clk);
        chk_en = 1'b0;
        bus.start = 1'b1; bus.op = 2'b00; bus.base = 8'd0; bus.len = 8'd8; bus.fill_val = 8'h40;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_en_async", 32'(bus.mem_en), 32'd0);
        check("rst_busy_async", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) mdl_mem[i] = 8'(8'h40 + i);
        mdl_sum = 16'd0;
        d2 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) d2++;
        end
        rst_n = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) d2++;
        end
        check("rst_no_done", 32'(d2), 32'd0);
        check("rst_writes", 32'(wr_cnt - w0), 32'd3);
        check("rst_ram2", 32'(ram[2]), 32'h42);
        check("rst_ram3", 32'(ram[3]), 32'd60);
        check_ram();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
